// File: rtl/uart_apb_pkg.sv
// Shared register map, CTRL/STATUS bit positions and TX state encoding for the
// UART APB control block.
package uart_apb_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_TX_EN  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_RX_NEMPTY = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_BUSY   = 2;
  localparam int STAT_OVERRUN   = 3;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_START  = 2'd1,
    T_ACTIVE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = 8,
  localparam int PTR_W   = $clog2(RX_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(RX_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are only visible once counted in.
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end for the UART pair: CTRL/STATUS/TXDATA/RXDATA decode,
// TX launch FSM with bounded wait-state stalls, RX byte buffering and interrupt.
module uart_apb_ctrl
  import uart_apb_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int MAX_WAIT = 255
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       rx_enable,
  input  logic       rx_done,
  input  logic [7:0] rx_parallel,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       irq
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int CNT_W  = $clog2(RX_DEPTH) + 1;

  logic [2:0]        ctrl_q, ctrl_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_q;
  logic              irq_q, irq_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  tx_state_e         tx_state_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;

  logic              access;
  logic              pready_c, pslverr_c;
  logic [7:0]        prdata_c;
  logic              ctrl_wr, ovr_clr, rx_pop, tx_launch;
  logic              rx_push;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        status;

  assign access  = PSEL & PENABLE;
  assign rx_push = rx_done & ~rx_done_q & ctrl_q[CTRL_RX_EN];

  always_comb begin
    status                 = '0;
    status[STAT_RX_NEMPTY] = (fifo_count != '0);
    status[STAT_RX_FULL]   = fifo_full;
    status[STAT_TX_BUSY]   = (tx_state_q != T_IDLE);
    status[STAT_OVERRUN]   = overrun_q;
  end

  // APB access decode: completion, read mux and single-shot side-effect strobes.
  always_comb begin
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    prdata_c  = '0;
    ctrl_wr   = 1'b0;
    ovr_clr   = 1'b0;
    rx_pop    = 1'b0;
    tx_launch = 1'b0;
    wait_d    = '0;
    if (access) begin
      pready_c = 1'b1;
      case (PADDR)
        ADDR_CTRL: begin
          if (PWRITE) ctrl_wr = 1'b1;
          else        prdata_c = {5'b0, ctrl_q};
        end
        ADDR_STATUS: begin
          if (PWRITE) ovr_clr = PWDATA[STAT_OVERRUN];
          else        prdata_c = status;
        end
        ADDR_TXDATA: begin
          if (!PWRITE || !ctrl_q[CTRL_TX_EN]) begin
            pslverr_c = 1'b1;
          end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
            pslverr_c = 1'b1;
          end else if (tx_state_q == T_IDLE) begin
            tx_launch = 1'b1;
          end else begin
            pready_c = 1'b0;
            wait_d   = wait_q + WAIT_W'(1);
          end
        end
        ADDR_RXDATA: begin
          if (PWRITE || fifo_empty) begin
            pslverr_c = 1'b1;
          end else begin
            prdata_c = fifo_rdata;
            rx_pop   = 1'b1;
          end
        end
        default: pslverr_c = 1'b1;
      endcase
    end
  end

  // Reset also masks the combinational response so a held access reads as idle.
  assign PREADY    = pready_c & ~PRESET;
  assign PSLVERR   = pslverr_c & ~PRESET;
  assign PRDATA    = PRESET ? 8'h00 : prdata_c;
  assign rx_enable = ctrl_q[CTRL_RX_EN];
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign irq       = irq_q;

  always_comb begin
    ctrl_d    = ctrl_wr ? PWDATA[2:0] : ctrl_q;
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (rx_push && fifo_full && !rx_pop) overrun_d = 1'b1;
    irq_d = ctrl_q[CTRL_IRQ_EN] & ((fifo_count != '0) | overrun_q);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
      rx_done_q <= 1'b0;
      irq_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      overrun_q <= overrun_d;
      rx_done_q <= rx_done;
      irq_q     <= irq_d;
      wait_q    <= wait_d;
    end
  end

  // TX sequencer: launch pulse lives exactly in T_START, data held until done.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state_q <= T_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          if (tx_launch) begin
            tx_state_q <= T_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= PWDATA;
          end
        end
        T_START: begin
          tx_state_q <= T_ACTIVE;
          tx_start_q <= 1'b0;
        end
        T_ACTIVE: begin
          if (tx_done) tx_state_q <= T_IDLE;
        end
        default: begin
          tx_state_q <= T_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .DATA_W   (8)
  ) u_rx_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (rx_push),
    .pop    (rx_pop),
    .wdata  (rx_parallel),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed bench for uart_apb_ctrl: APB transfers, RX/TX reference models and
// an expected-value queue consumed as the DUT responds.
module tb_uart_apb_ctrl;

  localparam int RX_DEPTH = 4;
  localparam int MAX_WAIT = 255;

  logic       PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR, rx_enable, rx_done, tx_start, tx_done, irq;
  logic [7:0] rx_parallel, tx_data;

  uart_apb_ctrl #(.RX_DEPTH(RX_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .rx_enable(rx_enable),
    .rx_done(rx_done), .rx_parallel(rx_parallel), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] rx_model[$];
  bit         ovr_model = 0;
  bit         busy_model = 0;
  logic [2:0] ctrl_model = 3'b000;
  logic [7:0] tx_exp[$];
  logic [7:0] tx_seen[$];
  int         n_starts = 0;
  int         w;
  logic [7:0] head;

  always @(negedge PCLK) begin
    if (tx_start === 1'b1) begin
      tx_seen.push_back(tx_data);
      n_starts++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_underflow obs=0x%0h exp=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s obs=0x%0h exp=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] v);
    expect_v(tag, v);
    chk(obs);
  endtask

  function automatic logic [7:0] status_model();
    return {4'b0, ovr_model, busy_model,
            rx_model.size() == RX_DEPTH, rx_model.size() != 0};
  endfunction

  function automatic logic irq_model();
    return ctrl_model[2] & ((rx_model.size() != 0) | ovr_model);
  endfunction

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err, output logic rdy,
                     output int waited);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    waited = 0;
    while (PREADY !== 1'b1 && waited < 2000) begin
      @(negedge PCLK);
      #1;
      waited++;
    end
    rd = PRDATA; err = PSLVERR; rdy = PREADY;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] addr,
                        input logic [7:0] exp_d, input logic exp_e);
    logic [7:0] d; logic e, r; int wt;
    expect_v({tag, "_rdy"}, 1);
    expect_v({tag, "_data"}, {24'b0, exp_d});
    expect_v({tag, "_err"}, {31'b0, exp_e});
    apb(1'b0, addr, 8'h00, d, e, r, wt);
    chk({31'b0, r}); chk({24'b0, d}); chk({31'b0, e});
  endtask

  task automatic wr_reg(input string tag, input logic [7:0] addr, input logic [7:0] wd,
                        input logic exp_e, output int wt);
    logic [7:0] d; logic e, r;
    expect_v({tag, "_rdy"}, 1);
    expect_v({tag, "_err"}, {31'b0, exp_e});
    apb(1'b1, addr, wd, d, e, r, wt);
    chk({31'b0, r}); chk({31'b0, e});
  endtask

  task automatic rx_byte(input logic [7:0] b, input int len);
    @(negedge PCLK);
    rx_parallel = b; rx_done = 1'b1;
    if (ctrl_model[0]) begin
      if (rx_model.size() < RX_DEPTH) rx_model.push_back(b);
      else ovr_model = 1'b1;
    end
    repeat (len - 1) @(negedge PCLK);
    @(negedge PCLK);
    rx_done = 1'b0; rx_parallel = 8'h00;
  endtask

  task automatic rd_rx(input string tag);
    if (rx_model.size() == 0) rd_reg(tag, 8'h0C, 8'h00, 1'b1);
    else rd_reg(tag, 8'h0C, rx_model.pop_front(), 1'b0);
  endtask

  task automatic tx_compare(input string tag);
    chk_now({tag, "_count"}, tx_seen.size(), tx_exp.size());
    while (tx_seen.size() != 0 && tx_exp.size() != 0)
      chk_now({tag, "_byte"}, {24'b0, tx_seen.pop_front()}, {24'b0, tx_exp.pop_front()});
    tx_seen.delete();
    tx_exp.delete();
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00; rx_done = 1'b0; rx_parallel = 8'h00; tx_done = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    chk_now("reset_outputs", {PRDATA, PREADY, PSLVERR, rx_enable, tx_start, irq}, 0);
    chk_now("reset_tx_data", {24'b0, tx_data}, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // 1: register access basics
    rd_reg("t1_status", 8'h04, 8'h00, 1'b0);
    wr_reg("t1_ctrl_wr", 8'h00, 8'h07, 1'b0, w);
    chk_now("t1_ctrl_wr_waits", w, 0);
    ctrl_model = 3'b111;
    rd_reg("t1_ctrl_rd", 8'h00, 8'h07, 1'b0);
    chk_now("t1_rx_enable", {31'b0, rx_enable}, 1);

    // 2: two received bytes, the second held high for several cycles
    rx_byte(8'hA5, 1);
    rx_byte(8'h3C, 3);
    rd_reg("t2_status", 8'h04, status_model(), 1'b0);
    chk_now("t2_irq", {31'b0, irq}, {31'b0, irq_model()});
    rd_rx("t2_rx0");
    rd_rx("t2_rx1");
    rd_rx("t2_rx_empty");

    // 3: overrun, clear, drain in order
    for (int i = 0; i <= RX_DEPTH; i++) rx_byte(8'h10 + 8'(i), 1);
    rd_reg("t3_status_ovr", 8'h04, status_model(), 1'b0);
    chk_now("t3_status_is_0B", {24'b0, status_model()}, 32'h0B);
    chk_now("t3_irq", {31'b0, irq}, {31'b0, irq_model()});
    wr_reg("t3_clr_ovr", 8'h04, 8'h08, 1'b0, w);
    ovr_model = 1'b0;
    rd_reg("t3_status_clr", 8'h04, status_model(), 1'b0);
    for (int i = 0; i < RX_DEPTH; i++) rd_rx("t3_drain");
    repeat (2) @(negedge PCLK);
    chk_now("t3_irq_low", {31'b0, irq}, {31'b0, irq_model()});
    wr_reg("t3_rx_off", 8'h00, 8'h06, 1'b0, w);
    ctrl_model = 3'b110;
    rx_byte(8'h77, 1);
    rd_reg("t3_no_push_disabled", 8'h04, status_model(), 1'b0);
    wr_reg("t3_rx_on", 8'h00, 8'h07, 1'b0, w);
    ctrl_model = 3'b111;

    // 4: launch then stalled second launch released by tx_done
    wr_reg("t4_tx55", 8'h08, 8'h55, 1'b0, w);
    tx_exp.push_back(8'h55);
    busy_model = 1'b1;
    fork
      begin
        repeat (12) @(negedge PCLK);
        tx_done = 1'b1;
        @(negedge PCLK);
        tx_done = 1'b0;
      end
    join_none
    wr_reg("t4_tx66", 8'h08, 8'h66, 1'b0, w);
    tx_exp.push_back(8'h66);
    chk_now("t4_stalled", {31'b0, (w > 5)}, 1);
    repeat (3) @(negedge PCLK);
    chk_now("t4_start_pulses", n_starts, 2);
    tx_compare("t4_tx");
    chk_now("t4_tx_data_held", {24'b0, tx_data}, 32'h66);
    rd_reg("t4_status_busy", 8'h04, status_model(), 1'b0);

    // 5: stall timeout drops the byte; tx_en=0 and bad accesses error out
    wr_reg("t5_timeout", 8'h08, 8'h77, 1'b1, w);
    chk_now("t5_wait_cycles", w, MAX_WAIT);
    repeat (3) @(negedge PCLK);
    chk_now("t5_no_launch", n_starts, 2);
    @(negedge PCLK); tx_done = 1'b1;
    @(negedge PCLK); tx_done = 1'b0;
    busy_model = 1'b0;
    rd_reg("t5_status_idle", 8'h04, status_model(), 1'b0);
    wr_reg("t5_ctrl_txoff", 8'h00, 8'h05, 1'b0, w);
    ctrl_model = 3'b101;
    wr_reg("t5_tx_disabled", 8'h08, 8'h12, 1'b1, w);
    chk_now("t5_tx_disabled_waits", w, 0);
    repeat (3) @(negedge PCLK);
    chk_now("t5_tx_disabled_nolaunch", n_starts, 2);
    wr_reg("t5_ctrl_txon", 8'h00, 8'h07, 1'b0, w);
    ctrl_model = 3'b111;
    rd_reg("t5_unmapped", 8'h10, 8'h00, 1'b1);
    rd_reg("t5_txdata_read", 8'h08, 8'h00, 1'b1);
    wr_reg("t5_rxdata_write", 8'h0C, 8'hAA, 1'b1, w);
    rd_reg("t5_status_after_err", 8'h04, status_model(), 1'b0);

    // 6: push and pop in the same cycle while full
    for (int i = 0; i < RX_DEPTH; i++) rx_byte(8'hC0 + 8'(i), 1);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0C;
    @(negedge PCLK);
    PENABLE = 1'b1; rx_parallel = 8'hEE; rx_done = 1'b1;
    #1;
    head = rx_model.pop_front();
    rx_model.push_back(8'hEE);
    chk_now("t6_pop_data", {24'b0, PRDATA}, {24'b0, head});
    chk_now("t6_pop_resp", {30'b0, PREADY, PSLVERR}, 32'h2);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; rx_done = 1'b0;
    rd_reg("t6_status_full", 8'h04, status_model(), 1'b0);
    for (int i = 0; i < RX_DEPTH; i++) rd_rx("t6_drain");
    rd_rx("t6_drain_empty");

    // 6b: asynchronous reset while a byte is in flight
    rx_byte(8'h5A, 1);
    wr_reg("t6_tx99", 8'h08, 8'h99, 1'b0, w);
    tx_exp.push_back(8'h99);
    repeat (3) @(negedge PCLK);
    chk_now("t6_irq_before_rst", {31'b0, irq}, 1);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    chk_now("t6_pre_rst_ready", {31'b0, PREADY}, 1);
    #2;
    PRESET = 1'b1;
    #1;
    chk_now("t6_rst_outputs", {PRDATA, PREADY, PSLVERR, rx_enable, tx_start, irq}, 0);
    chk_now("t6_rst_tx_data", {24'b0, tx_data}, 0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    rx_model.delete(); ovr_model = 1'b0; busy_model = 1'b0; ctrl_model = 3'b000;
    rd_reg("t6_status_after_rst", 8'h04, status_model(), 1'b0);
    rd_reg("t6_ctrl_after_rst", 8'h00, 8'h00, 1'b0);
    repeat (5) @(negedge PCLK);
    chk_now("t6_no_reissue", n_starts, 3);
    tx_compare("t6_tx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
